// File: rtl/layer2_argmax_pkg.sv
// Shared constants, FSM state type and lane helper for the layer-2 argmax stage.
package layer2_argmax_pkg;

  localparam int L2_NUM_NEURONS = 10;
  localparam int L2_ACC_W       = 48;
  localparam int L2_IDX_W       = $clog2(L2_NUM_NEURONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic signed [L2_ACC_W-1:0] lane_extract(
    input logic [L2_NUM_NEURONS*L2_ACC_W-1:0] bus,
    input logic [L2_IDX_W-1:0]                k
  );
    return bus[k*L2_ACC_W +: L2_ACC_W];
  endfunction

endpackage

// File: rtl/layer2_argmax_cmp_cell.sv
// Combinational signed strict-greater compare-select; ties keep the current entry.
module argmax_cmp_cell #(
  parameter int ACC_W = 48,
  parameter int IDX_W = 4
) (
  input  logic signed [ACC_W-1:0] cur_val,
  input  logic        [IDX_W-1:0] cur_idx,
  input  logic signed [ACC_W-1:0] cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
  output logic signed [ACC_W-1:0] sel_val,
  output logic        [IDX_W-1:0] sel_idx
);

  always_comb begin
    if (cand_val > cur_val) begin
      sel_val = cand_val;
      sel_idx = cand_idx;
    end else begin
      sel_val = cur_val;
      sel_idx = cur_idx;
    end
  end

endmodule

// File: rtl/layer2_argmax.sv
// Snapshot-and-scan argmax over the layer-2 accumulator lanes, one lane per clock.
// Optional runner-up/margin outputs are built when ARGMAX_MARGIN_EN is defined.
module layer2_argmax
  import layer2_argmax_pkg::*;
#(
  parameter int NUM_NEURONS = L2_NUM_NEURONS,
  parameter int ACC_W       = L2_ACC_W,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_NEURONS*ACC_W-1:0] layer_in,
  input  logic                         start,
  output logic                         busy,
  output logic                         valid,
  output logic [IDX_W-1:0]             digit,
  output logic signed [ACC_W-1:0]      max_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [IDX_W-1:0]             second_digit,
  output logic [ACC_W:0]               margin
`endif
);

  state_t                         state_q, state_d;
  logic [NUM_NEURONS*ACC_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]        best_val_q, best_val_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
  logic                           busy_q, busy_d;
  logic [IDX_W-1:0]               digit_q, digit_d;
  logic signed [ACC_W-1:0]        max_q, max_d;

  logic signed [ACC_W-1:0]        lane_val;
  logic signed [ACC_W-1:0]        best_sel_val;
  logic [IDX_W-1:0]               best_sel_idx;
  logic                           last_lane;

  assign lane_val  = lane_extract(snap_q, idx_q);
  assign last_lane = (idx_q == IDX_W'(NUM_NEURONS - 1));

  argmax_cmp_cell #(.ACC_W(ACC_W), .IDX_W(IDX_W)) u_best_cmp (
    .cur_val  (best_val_q),
    .cur_idx  (best_idx_q),
    .cand_val (lane_val),
    .cand_idx (idx_q),
    .sel_val  (best_sel_val),
    .sel_idx  (best_sel_idx)
  );

`ifdef ARGMAX_MARGIN_EN
  logic signed [ACC_W-1:0] sec_val_q, sec_val_d;
  logic [IDX_W-1:0]        sec_idx_q, sec_idx_d;
  logic [IDX_W-1:0]        sec_digit_q, sec_digit_d;
  logic [ACC_W:0]          margin_q, margin_d;
  logic signed [ACC_W-1:0] sec_sel_val, sec_nx_val;
  logic [IDX_W-1:0]        sec_sel_idx, sec_nx_idx;

  argmax_cmp_cell #(.ACC_W(ACC_W), .IDX_W(IDX_W)) u_sec_cmp (
    .cur_val  (sec_val_q),
    .cur_idx  (sec_idx_q),
    .cand_val (lane_val),
    .cand_idx (idx_q),
    .sel_val  (sec_sel_val),
    .sel_idx  (sec_sel_idx)
  );

  // The scanned index always exceeds best_idx_q, so a changed index means a new maximum.
  always_comb begin
    if (best_sel_idx != best_idx_q) begin
      sec_nx_val = best_val_q;
      sec_nx_idx = best_idx_q;
    end else begin
      sec_nx_val = sec_sel_val;
      sec_nx_idx = sec_sel_idx;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    busy_d     = busy_q;
    digit_d    = digit_q;
    max_d      = max_q;
`ifdef ARGMAX_MARGIN_EN
    sec_val_d   = sec_val_q;
    sec_idx_d   = sec_idx_q;
    sec_digit_d = sec_digit_q;
    margin_d    = margin_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = layer_in;
          best_val_d = lane_extract(layer_in, '0);
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
          state_d    = SCAN;
`ifdef ARGMAX_MARGIN_EN
          // Most-negative seed value tagged as lane 1 keeps all-tie cases at the lowest index.
          sec_val_d = {1'b1, {(ACC_W-1){1'b0}}};
          sec_idx_d = IDX_W'(1);
`endif
        end
      end
      SCAN: begin
        best_val_d = best_sel_val;
        best_idx_d = best_sel_idx;
        idx_d      = idx_q + IDX_W'(1);
        busy_d     = !last_lane;
`ifdef ARGMAX_MARGIN_EN
        sec_val_d = sec_nx_val;
        sec_idx_d = sec_nx_idx;
`endif
        if (last_lane) begin
          idx_d   = '0;
          digit_d = best_sel_idx;
          max_d   = best_sel_val;
          state_d = DONE;
`ifdef ARGMAX_MARGIN_EN
          sec_digit_d = sec_nx_idx;
          margin_d    = {best_sel_val[ACC_W-1], best_sel_val} - {sec_nx_val[ACC_W-1], sec_nx_val};
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      busy_q     <= 1'b0;
      digit_q    <= '0;
      max_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
      sec_val_q   <= '0;
      sec_idx_q   <= '0;
      sec_digit_q <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      busy_q     <= busy_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
`ifdef ARGMAX_MARGIN_EN
      sec_val_q   <= sec_val_d;
      sec_idx_q   <= sec_idx_d;
      sec_digit_q <= sec_digit_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign valid     = (state_q == DONE);
  assign digit     = digit_q;
  assign max_score = max_q;
`ifdef ARGMAX_MARGIN_EN
  assign second_digit = sec_digit_q;
  assign margin       = margin_q;
`endif

endmodule

// File: doc/layer2_argmax.md
Name: layer2_argmax

Overview:
- Classifier output stage that sits directly downstream of the second fully-connected layer.
- Snapshots the packed signed 48-bit accumulator bus (one lane per output neuron/digit class) on a start pulse.
- Scans the lanes sequentially, one per clock, and reports the index of the largest score as the recognised digit, plus that score, with a one-cycle valid strobe.
- One comparator serves all lanes; the snapshot decouples the result from accumulators that keep changing.

Parameters:
NUM_NEURONS, 10, number of output classes/lanes; must be >= 2
ACC_W, 48, signed width of each accumulator lane
IDX_W, $clog2(NUM_NEURONS) (4), width of digit index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
layer_in  input  NUM_NEURONS*ACC_W  packed signed scores; lane k at [k*ACC_W +: ACC_W]
start  input  1  one-cycle request; sampled only in IDLE
busy  output  1  high from the edge after an accepted start until valid is asserted
valid  output  1  one-cycle result strobe
digit  output  IDX_W  index of maximum lane; held until the next result
max_score  output  ACC_W  signed value of maximum lane; held until the next result

Behaviour:
- Reset is asynchronous and active-low, one clock domain: clk, rst_n. While rst_n=0: state=IDLE, busy=0, valid=0, digit=0, max_score=0, scan index=0, snapshot cleared.
- State machine IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On start=1 at edge t: capture all of layer_in into the snapshot register.
  - In the same edge: best_val<=lane0, best_idx<=0, i<=1, go to SCAN.
- SCAN:
  - Each edge compares snap[i] to best_val using full ACC_W two's-complement signed compare.
  - Replace best only if snap[i] is strictly greater, so ties resolve to the lowest index.
  - i increments by 1; at i=NUM_NEURONS-1 the compare completes and the state goes to DONE.
- DONE:
  - digit<=best_idx, max_score<=best_val, valid=1 for exactly one cycle.
  - Next edge returns to IDLE.
- Latency: valid is high in the cycle after edge t+NUM_NEURONS-1. For N=10 that is 9 edges after the start edge. Back-to-back throughput is one result per N+1 cycles.
- start while busy, in DONE, or asserted for several cycles: only the IDLE-sampled edge counts; later pulses are ignored, not queued.
- A start in the DONE cycle is ignored.
- layer_in changing after the capture edge has no effect on the result.
- Reset mid-SCAN aborts the scan; no valid is emitted and outputs return to zero.
- No saturation or width growth: comparisons only, no arithmetic on scores.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Add outputs second_digit [IDX_W] and margin [ACC_W+1], both registered and updated with valid.
  - Track the runner-up in parallel. When a new maximum arrives, the old best moves to second. Otherwise snap[i] replaces second if strictly greater than it. Initialise second with lane1 handling so ties resolve to the lowest index.
  - margin = max_score - second_score, computed as an unsigned, non-negative ACC_W+1-bit result.
  - Outputs reset to 0.
- Undefined: ports and logic are absent; all other timing is identical.

Decomposition:
- Shared package layer2_argmax_pkg holds:
  - NUM_NEURONS, ACC_W, IDX_W defaults, matching the layer-2 neuron count and 48-bit accumulator width;
  - the state enum (IDLE, SCAN, DONE);
  - a lane-extract function.
- One natural sub-module: argmax_cmp_cell, a combinational signed strict-greater compare-select returning (val, idx). It is instantiated once, plus a second instance under ARGMAX_MARGIN_EN.

Test Plan:
- Lanes = {0,1,2,3,4,5,6,100,8,9}, start pulse -> busy 1 for 8 cycles, then valid=1 for one cycle, digit=7, max_score=100.
- Lanes 3 and 5 both = 2^47-1, rest = -5 -> digit=3. With all lanes = -2^47 -> digit=0, max_score=-2^47.
- All lanes negative {-10,-3,-7,...,-50}, max at lane 1 -> digit=1. Max at lane 9 only -> digit=9, confirming the last lane is compared.
- Scramble layer_in every cycle after start, with a second start pulsed mid-scan -> exactly one valid, result equals the captured snapshot; second start ignored.
- Assert rst_n=0 at scan cycle 4 -> busy, valid, digit and max_score go to 0 immediately. A new start after release gives a correct result with normal latency.
- ARGMAX_MARGIN_EN: lanes with max 50 at lane 2 and runner-up 45 at lane 6 -> second_digit=6, margin=5. Lane 0=100, lane 1=100 -> digit=0, second_digit=1, margin=0.
